// File: rtl/fetch_decode_queue_pkg.sv
// Shared pipeline definitions for the IF/ID boundary: widths, the pipeline NOP
// and the skid-queue state encoding.
package fetch_decode_queue_pkg;

    localparam int INSTR_W  = 32;
    localparam int BUNDLE_W = 24;
    localparam int PC_W     = 32;

    // ori $zero,$zero,0 and its decoded control bundle, also used by fetch.
    localparam logic [INSTR_W-1:0]  NOP_INSTR  = 32'h3400_0000;
    localparam logic [BUNDLE_W-1:0] NOP_BUNDLE = 24'h0E_2531;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/fetch_decode_queue_entry_reg.sv
// One skid-queue slot: an {instr, bundle, pc_seq} register with load enable and
// asynchronous active-low clear.
module queue_entry_reg #(
    parameter int IW = fetch_decode_queue_pkg::INSTR_W,
    parameter int BW = fetch_decode_queue_pkg::BUNDLE_W,
    parameter int PW = fetch_decode_queue_pkg::PC_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [IW-1:0] load_instr,
    input  logic [BW-1:0] load_bundle,
    input  logic [PW-1:0] load_pc_seq,
    output logic [IW-1:0] instr,
    output logic [BW-1:0] bundle,
    output logic [PW-1:0] pc_seq
);

    // NOTE: the payload is cleared on reset as well as the valid state, so a
    // reset mid-operation can never leave a stale entry behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: state is updated with <= so every register samples pre-edge values.
            instr  <= '0;
            bundle <= '0;
            pc_seq <= '0;
        end else if (load) begin
            instr  <= load_instr;
            bundle <= load_bundle;
            pc_seq <= load_pc_seq;
        end
    end

endmodule

// File: rtl/fetch_decode_queue.sv
// Decode-side 2-entry skid queue between fetch and decode, with branch-redirect
// flush (optionally keeping the delay slot) and a saturating drop counter.
module fetch_decode_queue #(
    parameter int IW = fetch_decode_queue_pkg::INSTR_W,
    parameter int BW = fetch_decode_queue_pkg::BUNDLE_W,
    parameter int PW = fetch_decode_queue_pkg::PC_W,
    parameter logic [IW-1:0] NOP_INSTR  = fetch_decode_queue_pkg::NOP_INSTR,
    parameter logic [BW-1:0] NOP_BUNDLE = fetch_decode_queue_pkg::NOP_BUNDLE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    input  logic [BW-1:0] in_bundle,
    input  logic [PW-1:0] in_pc_seq,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_instr,
    output logic [BW-1:0] out_bundle,
    output logic [PW-1:0] out_pc_seq,
    input  logic          flush,
    input  logic          flush_keep_slot,
    output logic [7:0]    drop_count
);
    import fetch_decode_queue_pkg::*;

    logic [1:0]    state, state_next;
    logic          push, pop;
    logic          e0_load, e0_from_e1, e1_load;
    logic [1:0]    remaining, candidates, dropped;
    logic [IW-1:0] e0_instr, e1_instr;
    logic [BW-1:0] e0_bundle, e1_bundle;
    logic [PW-1:0] e0_pc_seq, e1_pc_seq;

    // Ready depends only on registered state so decode stalls never reach fetch combinationally.
    assign in_ready  = reset && (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_instr  = out_valid ? e0_instr  : NOP_INSTR;
    assign out_bundle = out_valid ? e0_bundle : NOP_BUNDLE;
    assign out_pc_seq = out_valid ? e0_pc_seq : '0;

    assign remaining  = state - {1'b0, pop};
    assign candidates = remaining + {1'b0, push};

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        e0_load    = 1'b0;
        e0_from_e1 = 1'b0;
        e1_load    = 1'b0;
        dropped    = 2'd0;
        if (flush) begin
            if (flush_keep_slot && candidates != 2'd0) begin
                // Survivor is the oldest of {entries left after pop, pushed entry}.
                state_next = ST_ONE;
                dropped    = candidates - 2'd1;
                if (remaining == 2'd0) begin
                    e0_load = 1'b1;
                end else if (pop) begin
                    e0_load    = 1'b1;
                    e0_from_e1 = 1'b1;
                end
            end else begin
                state_next = ST_EMPTY;
                dropped    = candidates;
            end
        end else begin
            case (state)
                ST_EMPTY: if (push) begin
                    state_next = ST_ONE;
                    e0_load    = 1'b1;
                end
                ST_ONE: begin
                    if (push && pop) begin
                        e0_load = 1'b1;
                    end else if (push) begin
                        state_next = ST_TWO;
                        e1_load    = 1'b1;
                    end else if (pop) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_TWO: if (pop) begin
                    state_next = ST_ONE;
                    e0_load    = 1'b1;
                    e0_from_e1 = 1'b1;
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_EMPTY;
            drop_count <= 8'd0;
        end else begin
            state      <= state_next;
            drop_count <= sat_add8(drop_count, dropped);
        end
    end

    queue_entry_reg #(.IW(IW), .BW(BW), .PW(PW)) u_e0 (
        .clk         (clk),
        .reset       (reset),
        .load        (e0_load),
        .load_instr  (e0_from_e1 ? e1_instr  : in_instr),
        .load_bundle (e0_from_e1 ? e1_bundle : in_bundle),
        .load_pc_seq (e0_from_e1 ? e1_pc_seq : in_pc_seq),
        .instr       (e0_instr),
        .bundle      (e0_bundle),
        .pc_seq      (e0_pc_seq)
    );

    queue_entry_reg #(.IW(IW), .BW(BW), .PW(PW)) u_e1 (
        .clk         (clk),
        .reset       (reset),
        .load        (e1_load),
        .load_instr  (in_instr),
        .load_bundle (in_bundle),
        .load_pc_seq (in_pc_seq),
        .instr       (e1_instr),
        .bundle      (e1_bundle),
        .pc_seq      (e1_pc_seq)
    );

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: a queue-based reference model tracks
// the expected contents; a negedge monitor compares every visible output.
module tb_fetch_decode_queue;

    typedef struct packed {
        logic [31:0] instr;
        logic [23:0] bundle;
        logic [31:0] pc_seq;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] in_instr;
    logic [23:0] in_bundle;
    logic [31:0] in_pc_seq;
    logic        out_valid, out_ready;
    logic [31:0] out_instr;
    logic [23:0] out_bundle;
    logic [31:0] out_pc_seq;
    logic        flush, flush_keep_slot;
    logic [7:0]  drop_count;

    int     n_checks = 0;
    int     n_errors = 0;
    int     pops_seen = 0;
    entry_t exp_q[$];
    int     exp_drop = 0;

    fetch_decode_queue dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instr        (in_instr),
        .in_bundle       (in_bundle),
        .in_pc_seq       (in_pc_seq),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_bundle      (out_bundle),
        .out_pc_seq      (out_pc_seq),
        .flush           (flush),
        .flush_keep_slot (flush_keep_slot),
        .drop_count      (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: the queue contents as a list, flush applied to the candidate list.
    task automatic model_step();
        int n;
        entry_t keep;
        if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && exp_q.size() < 2 + (out_ready ? 0 : 0) && !(exp_q.size() == 2))
            exp_q.push_back('{in_instr, in_bundle, in_pc_seq});
        if (flush) begin
            n = exp_q.size();
            if (flush_keep_slot && n > 0) begin
                keep = exp_q[0];
                exp_q.delete();
                exp_q.push_back(keep);
                exp_drop += n - 1;
            end else begin
                exp_q.delete();
                exp_drop += n;
            end
            if (exp_drop > 255) exp_drop = 255;
        end
    endtask

    // Capture whether the queue was full before this edge's pop so push legality matches in_ready.
    initial begin
        forever begin
            int size_before;
            @(posedge clk);
            if (reset) begin
                size_before = exp_q.size();
                if (size_before > 0 && out_ready) begin
                    void'(exp_q.pop_front());
                end
                if (in_valid && size_before < 2) exp_q.push_back('{in_instr, in_bundle, in_pc_seq});
                if (flush) begin
                    int n;
                    entry_t keep;
                    n = exp_q.size();
                    if (flush_keep_slot && n > 0) begin
                        keep = exp_q[0];
                        exp_q.delete();
                        exp_q.push_back(keep);
                        exp_drop += n - 1;
                    end else begin
                        exp_q.delete();
                        exp_drop += n;
                    end
                    if (exp_drop > 255) exp_drop = 255;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge reset);
            exp_q.delete();
            exp_drop = 0;
        end
    end

    // Monitor: compares everything the DUT presents, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("rst_out_valid", out_valid, 0);
                check("rst_in_ready", in_ready, 0);
                check("rst_drop", drop_count, 0);
            end else begin
                check("out_valid", out_valid, exp_q.size() != 0);
                check("in_ready", in_ready, exp_q.size() < 2);
                check("drop_count", drop_count, exp_drop);
                if (exp_q.size() != 0) begin
                    check("head_instr", out_instr, exp_q[0].instr);
                    check("head_bundle", out_bundle, exp_q[0].bundle);
                    check("head_pc_seq", out_pc_seq, exp_q[0].pc_seq);
                end else begin
                    check("nop_instr", out_instr, 32'h3400_0000);
                    check("nop_bundle", out_bundle, 24'h0E_2531);
                    check("nop_pc_seq", out_pc_seq, 0);
                end
                if (out_valid && out_ready) pops_seen++;
            end
        end
    end

    task automatic step(input logic iv, input entry_t e, input logic ordy,
                        input logic fl, input logic kp);
        in_valid        = iv;
        in_instr        = e.instr;
        in_bundle       = e.bundle;
        in_pc_seq       = e.pc_seq;
        out_ready       = ordy;
        flush           = fl;
        flush_keep_slot = kp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        entry_t a, b, c, d, r, idle;
        a    = '{32'h8C01_0000, 24'h11_1111, 32'h0040_0004};
        b    = '{32'h2022_0005, 24'h22_2222, 32'h0040_0008};
        c    = '{32'hAC03_0010, 24'h33_3333, 32'h0040_000C};
        d    = '{32'h0800_0040, 24'h44_4444, 32'h0040_0100};
        idle = '0;

        reset = 1'b0;
        in_valid = 0; in_instr = 0; in_bundle = 0; in_pc_seq = 0;
        out_ready = 0; flush = 0; flush_keep_slot = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk); #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_instr", out_instr, 32'h3400_0000);
        check("reset_out_bundle", out_bundle, 24'h0E_2531);
        @(posedge clk); #1;

        // Fill while decode stalls, then drain in order.
        step(1, a, 0, 0, 0);
        step(1, b, 0, 0, 0);
        check("full_in_ready", in_ready, 0);
        check("stall_head", out_pc_seq, 32'h0040_0004);
        step(0, idle, 0, 0, 0);
        step(0, idle, 1, 0, 0);
        check("pop_order", out_pc_seq, 32'h0040_0008);
        step(0, idle, 1, 0, 0);
        check("drained", out_valid, 0);

        // Streaming at one entry per cycle.
        pops_seen = 0;
        for (int i = 0; i < 10; i++) begin
            r = '{$urandom, 24'($urandom), 32'h0040_1000 + 32'(4 * i)};
            step(1, r, 1, 0, 0);
        end
        step(0, idle, 1, 0, 0);
        check("stream_throughput", pops_seen, 10);

        // Pop + flush keeping the slot, then pop + flush discarding it.
        step(1, a, 0, 0, 0);
        step(1, b, 0, 0, 0);
        step(0, idle, 1, 1, 1);
        check("keep_head", out_pc_seq, 32'h0040_0008);
        check("keep_drop", drop_count, 0);
        step(0, idle, 1, 0, 0);
        step(1, a, 0, 0, 0);
        step(1, b, 0, 0, 0);
        step(0, idle, 1, 1, 0);
        check("discard_valid", out_valid, 0);
        check("discard_drop", drop_count, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r = '{$urandom, 24'($urandom), $urandom};
            step(1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
        step(0, idle, 1, 0, 0);
        step(0, idle, 1, 0, 0);

        // Push during keep-flush drops the newcomer; repeat until the counter saturates.
        step(1, a, 0, 0, 0);
        for (int i = 0; i < 300; i++) step(1, c, 0, 1, 1);
        check("sat_head", out_pc_seq, 32'h0040_0004);
        check("sat_drop", drop_count, 8'hFF);

        // Asynchronous reset in the middle of a cycle while full.
        step(1, b, 0, 0, 0);
        step(0, idle, 0, 0, 0);
        #1 reset = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_in_ready", in_ready, 0);
        check("async_out_instr", out_instr, 32'h3400_0000);
        check("async_drop", drop_count, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        step(1, d, 0, 0, 0);
        check("post_reset_head", out_pc_seq, 32'h0040_0100);
        check("post_reset_instr", out_instr, 32'h0800_0040);
        step(0, idle, 1, 0, 0);
        step(0, idle, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
